// File: rtl/dbf_rx_seq_ctrl_pkg.sv
// dbf_rx_seq_ctrl_pkg
//   Shared definitions for the DBF per-line receive sequencer: default widths
//   and the FSM state encoding used by dbf_rx_seq_ctrl.
package dbf_rx_seq_ctrl_pkg;

  localparam int unsigned ADDR_WD_DEF  = 8;
  localparam int unsigned TXLEN_WD_DEF = 8;
  localparam int unsigned RXLEN_WD_DEF = 16;
  localparam int unsigned ZLEN_WD_DEF  = 12;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StTx   = 2'd1,
    StRx   = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/dbf_zone_stepper.sv
// dbf_zone_stepper
//   Steps the focal-zone LUT address through the receive window.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     clear       return to address 0 with no strobe (line abort)
//     load        return to address 0 and strobe we (zone-0 preload)
//     enable      one RX cycle is being entered; advance the zone counter
//     zone_len    cycles per zone (0 = single zone, never steps)
//     num_zones   number of zones; address saturates at num_zones-1
//     addr, we    registered LUT address and one-cycle update strobe
module dbf_zone_stepper #(
  parameter int unsigned ADDR_WD = 8,
  parameter int unsigned ZLEN_WD = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic               enable,
  input  logic [ZLEN_WD-1:0] zone_len,
  input  logic [ADDR_WD-1:0] num_zones,
  output logic [ADDR_WD-1:0] addr,
  output logic               we
);

  logic [ZLEN_WD-1:0] zcnt_q;
  logic [ZLEN_WD-1:0] zcnt_inc;
  logic               can_step;

  // zcnt_q never exceeds zone_len-1, so the increment cannot wrap.
  assign zcnt_inc = zcnt_q + ZLEN_WD'(1);
  assign can_step = addr < (num_zones - ADDR_WD'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zcnt_q <= '0;
      addr   <= '0;
      we     <= 1'b0;
    end else begin
      we <= 1'b0;
      if (clear) begin
        zcnt_q <= '0;
        addr   <= '0;
      end else if (load) begin
        zcnt_q <= '0;
        addr   <= '0;
        we     <= 1'b1;
      end else if (enable && (zone_len != '0)) begin
        if (zcnt_inc == zone_len) begin
          zcnt_q <= '0;
          // Address and strobe move together; at the last zone both hold.
          if (can_step) begin
            addr <= addr + ADDR_WD'(1);
            we   <= 1'b1;
          end
        end else begin
          zcnt_q <= zcnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/dbf_rx_seq_ctrl.sv
// dbf_rx_seq_ctrl
//   Per-line sequencer for the DBF channel datapath. Opens the transmit window
//   (tx_en), then the beamform window (start), and steps the focal-zone LUT
//   address during receive. All outputs are registered.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     line_trig, abort  fire one line / synchronous abort to IDLE
//     cfg_*             line configuration, latched when a line is accepted
//     tx_en, start      transmit and beamform windows
//     dbf_lut_addr/we   focal-zone LUT address and update strobe
//     busy              high outside IDLE
//     line_done         pulse at normal end of line
//     trig_ovr          pulse for a trigger that arrived while busy
//     cfg_err           pulse for a trigger rejected by bad configuration
module dbf_rx_seq_ctrl
  import dbf_rx_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WD  = ADDR_WD_DEF,
  parameter int unsigned TXLEN_WD = TXLEN_WD_DEF,
  parameter int unsigned RXLEN_WD = RXLEN_WD_DEF,
  parameter int unsigned ZLEN_WD  = ZLEN_WD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                line_trig,
  input  logic                abort,
  input  logic [TXLEN_WD-1:0] cfg_tx_len,
  input  logic [RXLEN_WD-1:0] cfg_rx_len,
  input  logic [ZLEN_WD-1:0]  cfg_zone_len,
  input  logic [ADDR_WD-1:0]  cfg_num_zones,
  output logic                tx_en,
  output logic                start,
  output logic [ADDR_WD-1:0]  dbf_lut_addr,
  output logic                dbf_lut_we,
  output logic                busy,
  output logic                line_done,
  output logic                trig_ovr,
  output logic                cfg_err
);

  state_e              state_q;
  logic [TXLEN_WD-1:0] tx_len_q;
  logic [TXLEN_WD-1:0] tx_cnt_q;
  logic [RXLEN_WD-1:0] rx_len_q;
  logic [RXLEN_WD-1:0] rx_cnt_q;
  logic [ZLEN_WD-1:0]  zone_len_q;
  logic [ADDR_WD-1:0]  num_zones_q;

  logic cfg_ok;
  logic accept;
  logic tx_last;
  logic rx_last;
  logic zone_en;

  assign cfg_ok  = (cfg_rx_len != '0) && (cfg_num_zones != '0);
  assign accept  = (state_q == StIdle) && line_trig && cfg_ok && !abort;
  // Counters hold the 1-based index of the current cycle within its window.
  assign tx_last = tx_cnt_q >= tx_len_q;
  assign rx_last = rx_cnt_q >= rx_len_q;
  // Pulse on every edge that opens an RX cycle, so the zone counter counts
  // RX cycles and its strobe lands in the cycle that completes a zone.
  assign zone_en = !abort && (((state_q == StTx) && tx_last) ||
                              ((state_q == StRx) && !rx_last));

  dbf_zone_stepper #(
    .ADDR_WD (ADDR_WD),
    .ZLEN_WD (ZLEN_WD)
  ) u_zone_stepper (
    .clk       (clk),
    .rst       (rst),
    .clear     (abort),
    .load      (accept),
    .enable    (zone_en),
    .zone_len  (zone_len_q),
    .num_zones (num_zones_q),
    .addr      (dbf_lut_addr),
    .we        (dbf_lut_we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tx_len_q    <= '0;
      tx_cnt_q    <= '0;
      rx_len_q    <= '0;
      rx_cnt_q    <= '0;
      zone_len_q  <= '0;
      num_zones_q <= '0;
      tx_en       <= 1'b0;
      start       <= 1'b0;
      busy        <= 1'b0;
      line_done   <= 1'b0;
      trig_ovr    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      line_done <= 1'b0;
      cfg_err   <= 1'b0;
      // A trigger dropped by abort is not an overrun.
      trig_ovr  <= line_trig && !abort && (state_q != StIdle);
      if (abort) begin
        state_q  <= StIdle;
        tx_cnt_q <= '0;
        rx_cnt_q <= '0;
        tx_en    <= 1'b0;
        start    <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (line_trig) begin
              if (!cfg_ok) begin
                cfg_err <= 1'b1;
              end else begin
                // A zero transmit length still gives one TX cycle.
                tx_len_q    <= (cfg_tx_len == '0) ? TXLEN_WD'(1) : cfg_tx_len;
                rx_len_q    <= cfg_rx_len;
                zone_len_q  <= cfg_zone_len;
                num_zones_q <= cfg_num_zones;
                tx_cnt_q    <= TXLEN_WD'(1);
                state_q     <= StTx;
                tx_en       <= 1'b1;
                busy        <= 1'b1;
              end
            end
          end
          StTx: begin
            if (tx_last) begin
              rx_cnt_q <= RXLEN_WD'(1);
              state_q  <= StRx;
              tx_en    <= 1'b0;
              start    <= 1'b1;
            end else begin
              tx_cnt_q <= tx_cnt_q + TXLEN_WD'(1);
            end
          end
          StRx: begin
            if (rx_last) begin
              state_q   <= StDone;
              start     <= 1'b0;
              line_done <= 1'b1;
            end else begin
              rx_cnt_q <= rx_cnt_q + RXLEN_WD'(1);
            end
          end
          StDone: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dbf_rx_seq_ctrl.sv
module tb_dbf_rx_seq_ctrl;

  localparam int unsigned ADDR_WD  = 8;
  localparam int unsigned TXLEN_WD = 8;
  localparam int unsigned RXLEN_WD = 16;
  localparam int unsigned ZLEN_WD  = 12;
  localparam int          NCYC     = 40;

  logic                clk = 1'b0;
  logic                rst;
  logic                line_trig;
  logic                abort;
  logic [TXLEN_WD-1:0] cfg_tx_len;
  logic [RXLEN_WD-1:0] cfg_rx_len;
  logic [ZLEN_WD-1:0]  cfg_zone_len;
  logic [ADDR_WD-1:0]  cfg_num_zones;
  logic                tx_en;
  logic                start;
  logic [ADDR_WD-1:0]  dbf_lut_addr;
  logic                dbf_lut_we;
  logic                busy;
  logic                line_done;
  logic                trig_ovr;
  logic                cfg_err;

  dbf_rx_seq_ctrl #(
    .ADDR_WD  (ADDR_WD),
    .TXLEN_WD (TXLEN_WD),
    .RXLEN_WD (RXLEN_WD),
    .ZLEN_WD  (ZLEN_WD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .line_trig     (line_trig),
    .abort         (abort),
    .cfg_tx_len    (cfg_tx_len),
    .cfg_rx_len    (cfg_rx_len),
    .cfg_zone_len  (cfg_zone_len),
    .cfg_num_zones (cfg_num_zones),
    .tx_en         (tx_en),
    .start         (start),
    .dbf_lut_addr  (dbf_lut_addr),
    .dbf_lut_we    (dbf_lut_we),
    .busy          (busy),
    .line_done     (line_done),
    .trig_ovr      (trig_ovr),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-cycle record: bit k holds the output seen in cycle T0+k.
  logic [63:0]        r_tx, r_start, r_we, r_done, r_ovr, r_err, r_busy;
  logic [ADDR_WD-1:0] r_addr [64];

  typedef struct {
    int tx, rx, zl, nz;
    int e_ntx, e_sfirst, e_nstart, e_done, e_nwe, e_addr, e_nbusy, e_nerr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bt(input int i);
    logic [63:0] m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  function automatic int first_set(input logic [63:0] m);
    for (int i = 0; i < 64; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic set_cfg(input int tx, input int rx, input int zl, input int nz);
    cfg_tx_len    = TXLEN_WD'(tx);
    cfg_rx_len    = RXLEN_WD'(rx);
    cfg_zone_len  = ZLEN_WD'(zl);
    cfg_num_zones = ADDR_WD'(nz);
  endtask

  // Drives cycles 0..ncyc-1; trig/abort masks select the cycles with the
  // input high. cfg is overwritten with junk in cycle scramble_at.
  task automatic run_seq(input logic [63:0] trig_m, input logic [63:0] abort_m,
                         input int ncyc, input int scramble_at);
    r_tx = '0; r_start = '0; r_we = '0; r_done = '0;
    r_ovr = '0; r_err = '0; r_busy = '0;
    for (int i = 0; i < 64; i++) r_addr[i] = '0;
    for (int c = 0; c < ncyc; c++) begin
      line_trig = trig_m[c];
      abort     = abort_m[c];
      if (c == scramble_at) set_cfg(9, 2, 1, 2);
      @(posedge clk);
      #1;
      r_tx[c+1]    = tx_en;
      r_start[c+1] = start;
      r_we[c+1]    = dbf_lut_we;
      r_done[c+1]  = line_done;
      r_ovr[c+1]   = trig_ovr;
      r_err[c+1]   = cfg_err;
      r_busy[c+1]  = busy;
      r_addr[c+1]  = dbf_lut_addr;
    end
    line_trig = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic check_nominal(input string tag, input logic [63:0] exp_ovr);
    check({tag, "_tx"},    r_tx,    rng(1, 4));
    check({tag, "_start"}, r_start, rng(5, 24));
    check({tag, "_we"},    r_we,    bt(1) | bt(9) | bt(14) | bt(19) | bt(24));
    check({tag, "_done"},  r_done,  bt(25));
    check({tag, "_busy"},  r_busy,  rng(1, 25));
    check({tag, "_ovr"},   r_ovr,   exp_ovr);
    check({tag, "_err"},   r_err,   64'd0);
    check({tag, "_a9"},    64'(r_addr[9]),  64'd1);
    check({tag, "_a14"},   64'(r_addr[14]), 64'd2);
    check({tag, "_a19"},   64'(r_addr[19]), 64'd3);
    check({tag, "_a24"},   64'(r_addr[24]), 64'd4);
    check({tag, "_a25"},   64'(r_addr[25]), 64'd4);
  endtask

  initial begin
    //          tx rx  zl nz  ntx sf nst done nwe addr nbusy nerr
    vecs[0] = '{4, 20, 5, 8,  4,  5, 20, 25,  5,  4,   25,   0};
    vecs[1] = '{2, 30, 4, 3,  2,  3, 30, 33,  3,  2,   33,   0};
    vecs[2] = '{0, 3,  2, 4,  1,  2, 3,  5,   2,  1,   5,    0};
    vecs[3] = '{1, 10, 0, 8,  1,  2, 10, 12,  1,  0,   12,   0};
    vecs[4] = '{3, 0,  5, 4,  0,  0, 0,  0,   0,  0,   0,    1};
    vecs[5] = '{3, 5,  2, 0,  0,  0, 0,  0,   0,  0,   0,    1};
    vecs[6] = '{1, 6,  3, 8,  1,  2, 6,  8,   3,  2,   8,    0};
    vecs[7] = '{2, 8,  2, 1,  2,  3, 8,  11,  1,  0,   11,   0};

    rst       = 1'b1;
    line_trig = 1'b0;
    abort     = 1'b0;
    set_cfg(4, 20, 5, 8);
    #12;
    check("reset_outputs",
          64'({tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done, trig_ovr, cfg_err}),
          64'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      set_cfg(vecs[v].tx, vecs[v].rx, vecs[v].zl, vecs[v].nz);
      run_seq(64'd1, 64'd0, NCYC, -1);
      check($sformatf("v%0d_ntx", v),    64'($countones(r_tx)),    64'(vecs[v].e_ntx));
      check($sformatf("v%0d_sfirst", v), 64'(first_set(r_start)),  64'(vecs[v].e_sfirst));
      check($sformatf("v%0d_nstart", v), 64'($countones(r_start)), 64'(vecs[v].e_nstart));
      check($sformatf("v%0d_done", v),   64'(first_set(r_done)),   64'(vecs[v].e_done));
      check($sformatf("v%0d_nwe", v),    64'($countones(r_we)),    64'(vecs[v].e_nwe));
      check($sformatf("v%0d_addr", v),   64'(r_addr[NCYC]),        64'(vecs[v].e_addr));
      check($sformatf("v%0d_nbusy", v),  64'($countones(r_busy)),  64'(vecs[v].e_nbusy));
      check($sformatf("v%0d_nerr", v),   64'($countones(r_err)),   64'(vecs[v].e_nerr));
    end
    check("cfg_err_timing", r_err, 64'd0);
    set_cfg(3, 0, 5, 4);
    run_seq(64'd1, 64'd0, 4, -1);
    check("cfg_err_at_t1", r_err, bt(1));

    // Nominal line, exact per-cycle timing.
    set_cfg(4, 20, 5, 8);
    run_seq(64'd1, 64'd0, NCYC, -1);
    check_nominal("nom", 64'd0);

    // Overruns mid-RX and in DONE, with cfg changed after the latch.
    set_cfg(4, 20, 5, 8);
    run_seq(bt(0) | bt(10) | bt(25), 64'd0, NCYC, 10);
    check_nominal("ovr", bt(11) | bt(26));

    // Abort together with a trigger in RX cycle 12.
    set_cfg(4, 20, 5, 8);
    run_seq(bt(0) | bt(12), bt(12), NCYC, -1);
    check("abt_tx",    r_tx,    rng(1, 4));
    check("abt_start", r_start, rng(5, 12));
    check("abt_we",    r_we,    bt(1) | bt(9));
    check("abt_done",  r_done,  64'd0);
    check("abt_ovr",   r_ovr,   64'd0);
    check("abt_busy",  r_busy,  rng(1, 12));
    check("abt_a12",   64'(r_addr[12]), 64'd1);
    check("abt_a13",   64'(r_addr[13]), 64'd0);
    run_seq(64'd1, 64'd0, NCYC, -1);
    check_nominal("post_abt", 64'd0);

    // Asynchronous reset between edges during TX.
    line_trig = 1'b1;
    @(posedge clk);
    #1;
    line_trig = 1'b0;
    @(posedge clk);
    #1;
    check("arst_pre_tx",   64'(tx_en), 64'd1);
    check("arst_pre_busy", 64'(busy),  64'd1);
    #3 rst = 1'b1;
    #1;
    check("arst_tx",   64'(tx_en), 64'd0);
    check("arst_busy", 64'(busy),  64'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("arst_idle",
          64'({tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done}), 64'd0);
    run_seq(64'd1, 64'd0, NCYC, -1);
    check_nominal("post_rst", 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
